// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package rv_mc_pkg;

    localparam int unsigned OPCODE_WIDTH = 7;
    localparam int unsigned F3_WIDTH     = 3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_ILLEGAL
    } state_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    localparam logic [1:0] WBSEL_MEM = 2'd0;
    localparam logic [1:0] WBSEL_ALU = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_R     = 3'b010;
    localparam logic [2:0] ALUOP_I     = 3'b011;
    localparam logic [2:0] ALUOP_PASSB = 3'b100;

    localparam logic [F3_WIDTH-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_WIDTH-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_WIDTH-1:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake between controller and memory.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic AdrSrc;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output AdrSrc, input mem_ready);
    modport slave  (input mem_req, input mem_we, input AdrSrc, output mem_ready);
endinterface

// File: rtl/mc_branch_resolver.sv
// Combinational branch decision from funct3 and the comparator flags.
module mc_branch_resolver
    import rv_mc_pkg::*;
(
    input  logic [F3_WIDTH-1:0] i_funct3,
    input  logic                i_br_eq,
    input  logic                i_br_lt,
    output logic                o_taken,
    output logic                o_br_un
);

    always_comb begin
        o_taken = 1'b0;
        o_br_un = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_br_eq;
            F3_BNE:  o_taken = !i_br_eq;
            F3_BLT:  o_taken = i_br_lt;
            F3_BGE:  o_taken = !i_br_lt;
            F3_BLTU: begin o_taken = i_br_lt;  o_br_un = 1'b1; end
            F3_BGEU: begin o_taken = !i_br_lt; o_br_un = 1'b1; end
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback control and retire count.
// Optional MCC_ILLEGAL_TRAP_EN: unknown opcodes trap in ILLEGAL until reset and raise illegal_inst.
module multicycle_controller
    import rv_mc_pkg::*;
#(
    parameter int unsigned INST_WIDTH   = 32,
    parameter int unsigned IMMSEL_WIDTH = 3,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master mem,
    input  logic [INST_WIDTH-1:0]   inst,
    input  logic                    BrEq,
    input  logic                    BrLT,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    PCSel,
    output logic [IMMSEL_WIDTH-1:0] ImmSel,
    output logic [1:0]              ASel,
    output logic                    BSel,
    output logic [2:0]              ALUOp,
    output logic                    BrUn,
    output logic                    RegWEn,
    output logic [1:0]              WBSel,
    output logic                    instr_done,
    output logic [CNT_WIDTH-1:0]    retired_cnt
`ifdef MCC_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_inst
`endif
);

    state_e                    r_state;
    state_e                    w_next;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [OPCODE_WIDTH-1:0]   w_opcode;
    logic [F3_WIDTH-1:0]       w_funct3;
    logic                      w_taken;
    logic                      w_br_un;
    logic                      w_unused_inst;

    assign w_opcode      = inst[6:0];
    assign w_funct3      = inst[14:12];
    assign w_unused_inst = ^inst;

    mc_branch_resolver u_branch (
        .i_funct3 (w_funct3),
        .i_br_eq  (BrEq),
        .i_br_lt  (BrLT),
        .o_taken  (w_taken),
        .o_br_un  (w_br_un)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_R:              w_next = S_EXEC_R;
                    OP_IMM:            w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI, OP_AUIPC:  w_next = S_EXEC_U;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (w_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem.mem_ready) w_next = S_WB_MEM;
            S_MEM_WR:   if (mem.mem_ready) w_next = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: w_next = S_FETCH;
`ifdef MCC_ILLEGAL_TRAP_EN
            S_ILLEGAL:  w_next = S_ILLEGAL;
`else
            S_ILLEGAL:  w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Every control output is forced low while rst is high.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.AdrSrc  = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSel       = 1'b0;
        ImmSel      = '0;
        ASel        = ASEL_RS1;
        BSel        = 1'b0;
        ALUOp       = ALUOP_ADD;
        BrUn        = 1'b0;
        RegWEn      = 1'b0;
        WBSel       = WBSEL_MEM;
        instr_done  = 1'b0;
`ifdef MCC_ILLEGAL_TRAP_EN
        illegal_inst = 1'b0;
`endif
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    IRWrite     = mem.mem_ready;
                    PCWrite     = mem.mem_ready;
                end
                S_EXEC_R: ALUOp = ALUOP_R;
                S_EXEC_I: begin
                    ImmSel = IMMSEL_WIDTH'(IMM_I);
                    BSel   = 1'b1;
                    ALUOp  = ALUOP_I;
                end
                S_EXEC_U: begin
                    ImmSel = IMMSEL_WIDTH'(IMM_U);
                    ASel   = (w_opcode == OP_LUI) ? ASEL_ZERO : ASEL_PC;
                    BSel   = 1'b1;
                end
                S_MEM_ADDR: begin
                    ImmSel = (w_opcode == OP_LOAD) ? IMMSEL_WIDTH'(IMM_I) : IMMSEL_WIDTH'(IMM_S);
                    BSel   = 1'b1;
                end
                S_MEM_RD: begin
                    mem.mem_req = 1'b1;
                    mem.AdrSrc  = 1'b1;
                end
                S_MEM_WR: begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = 1'b1;
                    mem.AdrSrc  = 1'b1;
                    instr_done  = mem.mem_ready;
                end
                S_WB_ALU: begin
                    RegWEn     = 1'b1;
                    WBSel      = WBSEL_ALU;
                    instr_done = 1'b1;
                end
                S_WB_MEM: begin
                    RegWEn     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ImmSel     = IMMSEL_WIDTH'(IMM_B);
                    ASel       = ASEL_PC;
                    BSel       = 1'b1;
                    PCSel      = 1'b1;
                    PCWrite    = w_taken;
                    BrUn       = w_br_un;
                    instr_done = 1'b1;
                end
                S_JAL, S_JALR: begin
                    ImmSel     = (r_state == S_JAL) ? IMMSEL_WIDTH'(IMM_J) : IMMSEL_WIDTH'(IMM_I);
                    ASel       = (r_state == S_JAL) ? ASEL_PC : ASEL_RS1;
                    BSel       = 1'b1;
                    PCSel      = 1'b1;
                    PCWrite    = 1'b1;
                    RegWEn     = 1'b1;
                    WBSel      = WBSEL_PC4;
                    instr_done = 1'b1;
                end
`ifdef MCC_ILLEGAL_TRAP_EN
                S_ILLEGAL: illegal_inst = 1'b1;
`else
                S_ILLEGAL: instr_done = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             r_cnt <= '0;
        else if (instr_done) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign retired_cnt = rst ? '0 : r_cnt;

endmodule
